// File: rtl/trng_pooled.sv
// trng_pooled: pooled TRNG front end. Synchronizes NSRC raw oscillator bits,
// combines them into one bit, optionally von Neumann debiases the stream,
// packs WIDTH-bit words into a small FIFO and runs a repetition-count
// health test that latches a sticky failure.
module trng_pooled #(
   parameter int WIDTH     = 32,
   parameter int NSRC      = 3,
   parameter int COMBINE   = 0,
   parameter int VN_EN     = 1,
   parameter int DEPTH     = 4,
   parameter int RCT_LIMIT = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic [NSRC-1:0]            entropy_in,
   output logic [WIDTH-1:0]           rnd_data,
   output logic                       rnd_valid,
   input  logic                       rnd_ready,
   output logic [$clog2(DEPTH+1)-1:0] fill_level,
   output logic                       health_fail
);
   localparam int              AW      = $clog2(DEPTH);
   localparam int              FW      = $clog2(DEPTH+1);
   localparam int              CW      = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST    = CW'(WIDTH-1);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);
   localparam logic [7:0]      RCT_LIM = 8'(RCT_LIMIT);

   logic [NSRC-1:0]  sync1, sync2;
   logic [3:0]       ones;
   logic             xr, b;
   logic [WIDTH-1:0] coll, new_word, push_word;
   logic [CW-1:0]    bit_cnt;
   logic             held, vn_have, vn_first, last_b;
   logic [7:0]       rep_cnt, rep_next;
   logic             sample, emit, ebit, word_done, rct_trip, pop, push, full;
   logic [AW:0]      wptr, rptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign rnd_valid  = (wptr != rptr);
   assign fill_level = wptr - rptr;
   assign full       = (fill_level == FW'(DEPTH));
   assign rnd_data   = rnd_valid ? mem[rptr[AW-1:0]] : '0;

   // Two-flop synchronizer per raw source.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= entropy_in;
         sync2 <= sync1;
      end
   end

   // Combine synchronized sources: majority vote or XOR.
   always_comb begin
      ones = '0;
      xr   = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         ones = ones + {3'b000, sync2[i]};
         xr   = xr ^ sync2[i];
      end
      b = (COMBINE == 1) ? xr : (ones > 4'(NSRC / 2));
   end

   // Sampling qualifier, debias decision, health trip and FIFO push/pop.
   always_comb begin
      sample = enable && !health_fail && !held;
      pop    = rnd_valid && rnd_ready;
      if (VN_EN != 0) begin
         // Second sample of a pair: differing bits emit the first one.
         emit = sample && vn_have && (vn_first != b);
         ebit = vn_first;
      end else begin
         emit = sample;
         ebit = b;
      end
      word_done = emit && (bit_cnt == LAST);
      new_word  = {coll[WIDTH-2:0], ebit};
      rep_next  = (rep_cnt == 8'd0 || b != last_b) ? 8'd1 : rep_cnt + 8'd1;
      rct_trip  = sample && (rep_next == RCT_LIM);
      // A stalled word waits in the collector and drains on the next pop.
      push      = !rct_trip && ((word_done && (!full || pop)) || (held && enable && pop));
      push_word = held ? coll : new_word;
   end

   // Collector, bit counter, VN pair state and repetition counter.
   always_ff @(posedge clk) begin
      if (rst || !enable || health_fail || rct_trip) begin
         coll    <= '0;
         bit_cnt <= '0;
         held    <= 1'b0;
         vn_have <= 1'b0;
         vn_first<= 1'b0;
         rep_cnt <= '0;
         last_b  <= 1'b0;
      end else if (held) begin
         if (pop) begin
            held <= 1'b0;
            coll <= '0;
         end
      end else begin
         rep_cnt <= rep_next;
         last_b  <= b;
         if (VN_EN != 0) begin
            vn_have  <= !vn_have;
            vn_first <= b;
         end
         if (emit) begin
            if (word_done) begin
               bit_cnt <= '0;
               if (!full || pop) begin
                  coll <= '0;
               end else begin
                  coll <= new_word;
                  held <= 1'b1;
               end
            end else begin
               coll    <= new_word;
               bit_cnt <= bit_cnt + CNT_ONE;
            end
         end
      end
   end

   // Sticky health failure; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)           health_fail <= 1'b0;
      else if (rct_trip) health_fail <= 1'b1;
   end

   // FIFO pointers; a health trip flushes the queue.
   always_ff @(posedge clk) begin
      if (rst || rct_trip) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_ONE;
         if (pop)  rptr <= rptr + PTR_ONE;
      end
   end

   // FIFO storage, no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wptr[AW-1:0]] <= push_word;
   end

endmodule

// File: tb/tb_trng_pooled.sv
// tb_trng_pooled: directed vectors for a raw (XOR, no debias) instance and a
// debiased (majority, von Neumann) instance sharing clock and control.
module tb_trng_pooled;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, enable, rnd_ready;
   logic [2:0] ent_r, ent_v;
   logic [7:0] data_r, data_v;
   logic       valid_r, valid_v, hf_r, hf_v;
   logic [2:0] fill_r, fill_v;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-source encodings giving the wanted combined bit.
   logic [2:0] x1 [4] = '{3'b001, 3'b111, 3'b100, 3'b010};
   logic [2:0] x0 [4] = '{3'b000, 3'b011, 3'b101, 3'b110};
   logic [2:0] m1 [4] = '{3'b011, 3'b101, 3'b110, 3'b111};
   logic [2:0] m0 [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

   typedef struct {
      logic [63:0] bits;
      int          n;
      logic [7:0]  exp_data;
      logic        exp_valid;
      logic [2:0]  exp_fill;
   } vec_t;
   vec_t vecs [6];

   logic [7:0] order [4];

   trng_pooled #(.WIDTH(8), .NSRC(3), .COMBINE(1), .VN_EN(0), .DEPTH(4), .RCT_LIMIT(32)) u_raw (
      .clk(clk), .rst(rst), .enable(enable), .entropy_in(ent_r),
      .rnd_data(data_r), .rnd_valid(valid_r), .rnd_ready(rnd_ready),
      .fill_level(fill_r), .health_fail(hf_r));

   trng_pooled #(.WIDTH(8), .NSRC(3), .COMBINE(0), .VN_EN(1), .DEPTH(4), .RCT_LIMIT(32)) u_vn (
      .clk(clk), .rst(rst), .enable(enable), .entropy_in(ent_v),
      .rnd_data(data_v), .rnd_valid(valid_v), .rnd_ready(rnd_ready),
      .fill_level(fill_v), .health_fail(hf_v));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1; enable = 1'b0; rnd_ready = 1'b0; ent_r = '0; ent_v = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Feed n bits MSB first; the sync pipeline delays each sample two edges,
   // so enable goes high two cycles after the first bit is presented.
   task automatic run_stream(input logic [63:0] bits, input int n, input bit keep_en);
      logic v;
      for (int i = 0; i < n + 2; i++) begin
         @(negedge clk);
         v = (i < n) ? bits[n-1-i] : 1'b0;
         ent_r  = v ? x1[i%4] : x0[i%4];
         ent_v  = v ? m1[i%4] : m0[i%4];
         enable = (i >= 2);
      end
      @(negedge clk);
      if (!keep_en) enable = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; enable = 1'b0; rnd_ready = 1'b0; ent_r = '0; ent_v = '0;
      vecs[0] = '{64'hAA,   8,  8'hAA, 1'b1, 3'd1};
      vecs[1] = '{64'h5C,   8,  8'h5C, 1'b1, 3'd1};
      vecs[2] = '{64'h00,   8,  8'h00, 1'b1, 3'd1};
      vecs[3] = '{64'h55,   7,  8'h00, 1'b0, 3'd0};
      vecs[4] = '{64'hA5F,  12, 8'hA5, 1'b1, 3'd1};
      vecs[5] = '{64'hF00F, 16, 8'hF0, 1'b1, 3'd2};
      order   = '{8'h22, 8'h33, 8'h44, 8'h55};

      // Reset state
      do_reset;
      chk("reset data_r",  data_r,  8'h00);
      chk("reset valid_r", valid_r, 1'b0);
      chk("reset fill_r",  fill_r,  3'd0);
      chk("reset hf_r",    hf_r,    1'b0);
      chk("reset valid_v", valid_v, 1'b0);
      chk("reset hf_v",    hf_v,    1'b0);

      // Raw-path word assembly table
      for (int k = 0; k < 6; k++) begin
         do_reset;
         run_stream(vecs[k].bits, vecs[k].n, 1'b0);
         chk($sformatf("vec%0d data", k),  data_r,  vecs[k].exp_data);
         chk($sformatf("vec%0d valid", k), valid_r, vecs[k].exp_valid);
         chk($sformatf("vec%0d fill", k),  fill_r,  vecs[k].exp_fill);
      end

      // Von Neumann: 7 emitted bits leave no word, 8 give 0x40
      do_reset;
      run_stream(64'h1E155, 18, 1'b0);
      chk("vn partial valid", valid_v, 1'b0);
      chk("vn partial fill",  fill_v,  3'd0);
      do_reset;
      run_stream(64'h78555, 20, 1'b0);
      chk("vn word data",  data_v,  8'h40);
      chk("vn word valid", valid_v, 1'b1);
      chk("vn word fill",  fill_v,  3'd1);

      // FIFO full stall, pop releases held word, order preserved
      do_reset;
      run_stream(64'h1122334455, 40, 1'b1);
      chk("stall fill",   fill_r, 3'd4);
      chk("stall head",   data_r, 8'h11);
      repeat (3) @(negedge clk);
      chk("stall hold fill", fill_r, 3'd4);
      rnd_ready = 1'b1;
      @(negedge clk);
      rnd_ready = 1'b0;
      enable    = 1'b0;
      chk("pop push fill", fill_r, 3'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("order%0d", k), data_r, order[k]);
         rnd_ready = 1'b1;
         @(negedge clk);
      end
      chk("drained fill",  fill_r,  3'd0);
      chk("drained valid", valid_r, 1'b0);
      @(negedge clk);
      chk("empty pop fill", fill_r, 3'd0);
      rnd_ready = 1'b0;

      // Repetition-count health test on the debiased instance
      do_reset;
      run_stream(64'hAAAAAAAA, 32, 1'b0);
      chk("rct prefill fill", fill_v, 3'd2);
      chk("rct prefill data", data_v, 8'hFF);
      run_stream(64'h7FFFFFFF, 31, 1'b0);
      chk("rct 31 hf",   hf_v,   1'b0);
      chk("rct 31 fill", fill_v, 3'd2);
      run_stream(64'hFFFFFFFF, 32, 1'b0);
      chk("rct 32 hf",    hf_v,    1'b1);
      chk("rct 32 fill",  fill_v,  3'd0);
      chk("rct 32 valid", valid_v, 1'b0);
      chk("rct 32 data",  data_v,  8'h00);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("rct sticky hf", hf_v, 1'b1);
      do_reset;
      chk("rct reset hf", hf_v, 1'b0);

      // Reset mid-word and mid-pop, then a clean fresh word
      do_reset;
      run_stream(64'h3CC3, 16, 1'b0);
      chk("midrst prefill", fill_r, 3'd2);
      run_stream(64'h15, 5, 1'b1);
      rst = 1'b1; rnd_ready = 1'b1;
      @(negedge clk);
      chk("midrst data",  data_r,  8'h00);
      chk("midrst valid", valid_r, 1'b0);
      chk("midrst fill",  fill_r,  3'd0);
      chk("midrst hf",    hf_r,    1'b0);
      rst = 1'b0; rnd_ready = 1'b0; enable = 1'b0;
      run_stream(64'h96, 8, 1'b0);
      chk("fresh data",  data_r,  8'h96);
      chk("fresh valid", valid_r, 1'b1);
      chk("fresh fill",  fill_r,  3'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/trng_pooled.md
TRNG_POOLED -- requirements
Module: trng_pooled

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, output word width in bits (8..64).
REQ-002 SHALL provide parameter NSRC, default 3, number of raw entropy sources (1..8).
REQ-003 SHALL provide parameter COMBINE, default 0: 0 = majority vote of sources (NSRC odd), 1 = XOR of sources.
REQ-004 SHALL provide parameter VN_EN, default 1: 1 = von Neumann debiasing on, 0 = bypass.
REQ-005 SHALL provide parameter DEPTH, default 4, output FIFO depth in words (power of 2, >= 2).
REQ-006 SHALL provide parameter RCT_LIMIT, default 32, repetition-count failure threshold (2..255).
REQ-007 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port enable  input  1  1 = sample and collect entropy.
REQ-010 SHALL have port entropy_in  input  NSRC  raw, asynchronous oscillator outputs.
REQ-011 SHALL have port rnd_data  output  WIDTH  FIFO head word.
REQ-012 SHALL have port rnd_valid  output  1  FIFO non-empty.
REQ-013 SHALL have port rnd_ready  input  1  consumer accepts head word.
REQ-014 SHALL have port fill_level  output  clog2(DEPTH+1)  words held in the FIFO.
REQ-015 SHALL have port health_fail  output  1  sticky repetition-count failure flag.

Function
REQ-016 SHALL pass each entropy_in bit through its own 2-flop synchronizer; the combined bit b is formed from the second-stage flops per COMBINE.
REQ-017 SHALL take one sample of b per cycle while enable=1, health_fail=0 and the collector is not stalled (REQ-022).
REQ-018 With VN_EN=1, samples SHALL be paired in order (first, second): 01 -> emit 0, 10 -> emit 1, 00/11 -> emit nothing; with VN_EN=0 every sample SHALL be emitted.
REQ-019 The collector SHALL shift left and insert each emitted bit at the LSB; the first emitted bit of a word ends at bit WIDTH-1.
REQ-020 When the WIDTH-th bit is emitted, the completed word SHALL be written to the FIFO on that edge, the collector and bit counter SHALL clear, and rnd_valid SHALL be 1 the next cycle.
REQ-021 With VN_EN=0, enable held 1 and FIFO empty, rnd_valid SHALL rise exactly WIDTH cycles after the first sampling edge.
REQ-022 If a word completes while the FIFO is full with no pop that cycle, the collector SHALL hold the word and stop sampling until a pop occurs; the held word SHALL be written on the pop edge.
REQ-023 Pop SHALL occur on any edge with rnd_valid=1 and rnd_ready=1; simultaneous push and pop SHALL leave fill_level unchanged; words SHALL leave in write order.
REQ-024 rnd_data SHALL be the head word whenever rnd_valid=1; rnd_ready while empty SHALL have no effect.
REQ-025 The repetition counter SHALL count consecutive identical sampled b values (pre-debias), restarting at 1 on each change.
REQ-026 When the counter reaches RCT_LIMIT, health_fail SHALL be 1 from the next cycle, the FIFO SHALL be flushed (fill_level=0, rnd_valid=0), the collector and VN pair state SHALL clear, and sampling SHALL stop.
REQ-027 health_fail SHALL clear only on rst; enable has no effect on it.
REQ-028 Dropping enable SHALL clear the collector, bit counter, VN pair state and repetition counter on that edge, SHALL retain FIFO contents, and SHALL still allow pops.

Reset
REQ-029 On rst=1 at a clock edge, all synchronizers, collector, bit counter, VN pair state, repetition counter and FIFO pointers SHALL clear to 0.
REQ-030 Reset values SHALL be: rnd_data=0, rnd_valid=0, fill_level=0, health_fail=0.
REQ-031 rst SHALL override all other inputs in the same cycle, including mid-word and mid-pop.

Verification
REQ-032 WIDTH=8, NSRC=3, COMBINE=1, VN_EN=0: b alternates 1,0,... from the first sample -> rnd_data=0xAA, rnd_valid=1 after 8 sampling edges, fill_level=1.
REQ-033 WIDTH=8, VN_EN=1: b sequence 0,1, 1,1, 1,0, 0,0 then six further 01 pairs -> first word begins 0,1,0,0...; discarded pairs add no bits; word = 0x40 after 8 emitted bits.
REQ-034 DEPTH=4, rnd_ready=0, enable=1, healthy stream: fill_level reaches 4, the fifth word stalls; one pop -> fifth word written that edge, fill_level stays 4, order preserved.
REQ-035 RCT_LIMIT=32, b held 1 with 2 words buffered: health_fail=1 after 32nd identical sample, fill_level=0, rnd_valid=0; enable toggle leaves health_fail=1; rst clears it.
REQ-036 rst pulsed mid-word with fill_level=2 -> next cycle all outputs 0; resumed stream yields a complete fresh word, no partial carry-over.
